dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data-cache controller between the load/store unit and the byte-addressed data RAM. It serves load hits combinationally and sequences a refill from RAM on a load miss, stalling the CPU meanwhile. Stores are forwarded to RAM with their size strobes unchanged, and the cached copy is updated on a hit. It also keeps saturating hit and miss counters for performance measurement.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_ctrl_sat_counter.sv | 34 +++
 rtl/dcache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned NUM_SETS   = 8;
    localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
    localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - 2;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [ADDR_W-1:0]   data;
    } line_t;

endpackage

// File: rtl/dcache_ctrl_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment on enable unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Load hits are served combinationally; a load miss spends one extra cycle
// in REFILL while the word is fetched from the combinational RAM.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDRESS_LENGTH = ADDR_W,
    parameter int SETS           = NUM_SETS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_re,
    input  logic                      cpu_sw,
    input  logic                      cpu_sh,
    input  logic                      cpu_sb,
    input  logic [ADDRESS_LENGTH-1:0] cpu_addr,
    input  logic [ADDRESS_LENGTH-1:0] cpu_wd,
    input  logic                      flush,
    output logic [ADDRESS_LENGTH-1:0] cpu_rd,
    output logic                      stall,
    output logic [ADDRESS_LENGTH-1:0] mem_a,
    output logic [ADDRESS_LENGTH-1:0] mem_wd,
    output logic                      mem_sw,
    output logic                      mem_sh,
    output logic                      mem_sb,
    input  logic [ADDRESS_LENGTH-1:0] mem_rd,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);

    state_e                     state_q, state_d;
    line_t                      lines_q [SETS];
    line_t                      lines_d [SETS];
    logic [ADDRESS_LENGTH-1:2]  refill_word_q, refill_word_d;
    logic                       just_filled_q, just_filled_d;

    logic [1:0]            off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] refill_idx;
    logic [TAG_BITS-1:0]   refill_tag;
    line_t                 cur_line;
    logic                  hit;
    logic                  st_b, st_h, st_w, is_store;
    logic                  store_go, load_hit, load_miss, misaligned;
    logic [3:0]            byte_en;
    logic [ADDRESS_LENGTH-1:0] wd_shift, merged;

    assign off        = cpu_addr[1:0];
    assign idx        = cpu_addr[INDEX_BITS+1:2];
    assign tag        = cpu_addr[ADDRESS_LENGTH-1:INDEX_BITS+2];
    assign refill_idx = refill_word_q[INDEX_BITS+1:2];
    assign refill_tag = refill_word_q[ADDRESS_LENGTH-1:INDEX_BITS+2];
    assign cur_line   = lines_q[idx];
    assign hit        = cur_line.valid && (cur_line.tag == tag);

    // Byte strobes resolve with priority sb > sh > sw; any store beats a load.
    assign st_b       = cpu_sb;
    assign st_h       = cpu_sh && !cpu_sb;
    assign st_w       = cpu_sw && !cpu_sh && !cpu_sb;
    assign is_store   = cpu_sb || cpu_sh || cpu_sw;
    assign store_go   = (state_q == IDLE) && is_store;
    assign load_hit   = (state_q == IDLE) && cpu_re && !is_store && hit;
    assign load_miss  = (state_q == IDLE) && cpu_re && !is_store && !hit;
    assign misaligned = (st_h && (off == 2'd3)) || (st_w && (off != 2'd0));

    // Byte-lane merge of right-aligned store data into the cached word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        byte_en  = st_b ? (4'b0001 << off) : (st_h ? (4'b0011 << off) : 4'b1111);
        wd_shift = cpu_wd << {off, 3'b000};
        merged   = cur_line.data;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged[8*b +: 8] = wd_shift[8*b +: 8];
            end
        end
    end

    // CPU and RAM side outputs; all held quiet while reset is asserted.
    always_comb begin
        cpu_rd = '0;
        stall  = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        mem_sw = 1'b0;
        mem_sh = 1'b0;
        mem_sb = 1'b0;
        if (rst_n) begin
            if (state_q == REFILL) begin
                stall = 1'b1;
                mem_a = {refill_word_q, 2'b00};
            end else if (store_go) begin
                mem_a  = cpu_addr;
                mem_wd = cpu_wd;
                mem_sw = st_w;
                mem_sh = st_h;
                mem_sb = st_b;
            end else if (load_hit) begin
                cpu_rd = cur_line.data;
            end else if (load_miss) begin
                stall = 1'b1;
                mem_a = {cpu_addr[ADDRESS_LENGTH-1:2], 2'b00};
            end
        end
    end

    // Next FSM state and line contents; flush overrides everything at the edge.
    always_comb begin
        state_d       = state_q;
        lines_d       = lines_q;
        refill_word_d = refill_word_q;
        just_filled_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d       = REFILL;
                    refill_word_d = cpu_addr[ADDRESS_LENGTH-1:2];
                end else if (store_go && hit) begin
                    if (misaligned) begin
                        lines_d[idx].valid = 1'b0;
                    end else begin
                        lines_d[idx].data = merged;
                    end
                end
            end
            REFILL: begin
                state_d = IDLE;
                if (!flush) begin
                    lines_d[refill_idx] = '{valid: 1'b1, tag: refill_tag, data: mem_rd};
                    just_filled_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            for (int i = 0; i < SETS; i++) begin
                lines_d[i].valid = 1'b0;
            end
        end
    end

    // FSM, line array and refill bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            refill_word_q <= '0;
            just_filled_q <= 1'b0;
            // NOTE: the whole line array is reset; it is tiny, and it keeps tag/data free of X as well as clearing valid.
            for (int i = 0; i < SETS; i++) begin
                lines_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            refill_word_q <= refill_word_d;
            just_filled_q <= just_filled_d;
            lines_q       <= lines_d;
        end
    end

    // The lookup right after a fill is the replayed miss, so it is not a hit.
    sat_counter u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_hit && !just_filled_q),
        .count (hit_count)
    );

    sat_counter u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_miss),
        .count (miss_count)
    );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with a small byte-strobed RAM.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_sw, cpu_sh, cpu_sb, flush;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        stall;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_sw, mem_sh, mem_sb;
    logic [15:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_re     (cpu_re),
        .cpu_sw     (cpu_sw),
        .cpu_sh     (cpu_sh),
        .cpu_sb     (cpu_sb),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .flush      (flush),
        .cpu_rd     (cpu_rd),
        .stall      (stall),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_sw     (mem_sw),
        .mem_sh     (mem_sh),
        .mem_sb     (mem_sb),
        .mem_rd     (mem_rd),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // RAM model: 256 words aliased on addr[9:2]; misaligned stores are ignored.
    logic [31:0] ram [256];
    assign mem_rd = ram[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_sb) begin
            ram[mem_a[9:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
        end else if (mem_sh && (mem_a[1:0] != 2'd3)) begin
            ram[mem_a[9:2]][8*mem_a[1:0] +: 8]     <= mem_wd[7:0];
            ram[mem_a[9:2]][8*mem_a[1:0] + 8 +: 8] <= mem_wd[15:8];
        end else if (mem_sw && (mem_a[1:0] == 2'd0)) begin
            ram[mem_a[9:2]] <= mem_wd;
        end
    end

    typedef struct {
        logic        re, sw, sh, sb, fl;
        logic [31:0] addr, wd;
        logic        e_stall;
        logic [31:0] e_rd, e_mem_a;
        logic [15:0] e_hc, e_mc;
        logic [2:0]  e_strb;   // {mem_sw, mem_sh, mem_sb}
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic re, sw, sh, sb, fl,
                                input logic [31:0] addr, wd,
                                input logic e_stall, input logic [31:0] e_rd, e_mem_a,
                                input logic [15:0] e_hc, e_mc, input logic [2:0] e_strb);
        vec_t v;
        v.re = re; v.sw = sw; v.sh = sh; v.sb = sb; v.fl = fl;
        v.addr = addr; v.wd = wd;
        v.e_stall = e_stall; v.e_rd = e_rd; v.e_mem_a = e_mem_a;
        v.e_hc = e_hc; v.e_mc = e_mc; v.e_strb = e_strb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_re = v.re; cpu_sw = v.sw; cpu_sh = v.sh; cpu_sb = v.sb; flush = v.fl;
        cpu_addr = v.addr; cpu_wd = v.wd;
    endtask

    localparam logic [31:0] A = 32'h0001_0000;
    localparam logic [31:0] B = 32'h0001_0020;   // same index as A, different tag

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[0] = 32'hDEAD_BEEF;

        rst_n = 1'b0;
        cpu_re = 0; cpu_sw = 0; cpu_sh = 0; cpu_sb = 0; flush = 0;
        cpu_addr = '0; cpu_wd = '0;

        // Reset state.
        #1;
        check("reset stall", {31'b0, stall}, 32'h0);
        check("reset mem_a", mem_a, 32'h0);
        check("reset cpu_rd", cpu_rd, 32'h0);
        check("reset hit_count", {16'b0, hit_count}, 32'h0);
        check("reset miss_count", {16'b0, miss_count}, 32'h0);

        //               re sw sh sb fl addr    wd             stall rd             mem_a   hc mc strb
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             1, 0,             A,     0, 0, 3'b000)); // 0 miss
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             1, 0,             A,     0, 1, 3'b000)); // 1 refill
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             0, 32'hDEADBEEF,  0,     0, 1, 3'b000)); // 2 replay, uncounted
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             0, 32'hDEADBEEF,  0,     0, 1, 3'b000)); // 3 real hit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0,             0, 0,             0,     1, 1, 3'b000)); // 4 idle
        vecs.push_back(mk(0, 0, 0, 1, 0, A + 2, 32'h55,        0, 0,             A + 2, 1, 1, 3'b001)); // 5 sb hit
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             0, 32'hDE55BEEF,  0,     1, 1, 3'b000)); // 6 merged hit
        vecs.push_back(mk(0, 1, 0, 0, 0, B,     32'h12345678,  0, 0,             B,     2, 1, 3'b100)); // 7 sw miss
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 1, 3'b000)); // 8 miss
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 2, 3'b000)); // 9
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             0, 32'h12345678,  0,     2, 2, 3'b000)); // 10
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             1, 0,             A,     2, 2, 3'b000)); // 11 conflict
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             1, 0,             A,     2, 3, 3'b000)); // 12
        vecs.push_back(mk(1, 0, 0, 0, 0, A,     0,             0, 32'hDE55BEEF,  0,     2, 3, 3'b000)); // 13
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 3, 3'b000)); // 14 conflict
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 4, 3'b000)); // 15
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             0, 32'h12345678,  0,     2, 4, 3'b000)); // 16
        vecs.push_back(mk(0, 0, 1, 0, 0, B + 3, 32'hAAAA,      0, 0,             B + 3, 2, 4, 3'b010)); // 17 misaligned sh
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 4, 3'b000)); // 18 line invalidated
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     2, 5, 3'b000)); // 19
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             0, 32'h12345678,  0,     2, 5, 3'b000)); // 20 unmerged
        vecs.push_back(mk(0, 0, 1, 0, 0, B,     32'hBEEF,      0, 0,             B,     2, 5, 3'b010)); // 21 sh hit
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             0, 32'h1234BEEF,  0,     2, 5, 3'b000)); // 22 hit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0,             0, 0,             0,     3, 5, 3'b000)); // 23
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,     0,             0, 0,             0,     3, 5, 3'b000)); // 24 flush
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     3, 5, 3'b000)); // 25 miss after flush
        vecs.push_back(mk(1, 0, 0, 0, 1, B,     0,             1, 0,             B,     3, 6, 3'b000)); // 26 flush in REFILL
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     3, 6, 3'b000)); // 27 misses again
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             1, 0,             B,     3, 7, 3'b000)); // 28
        vecs.push_back(mk(1, 0, 0, 0, 0, B,     0,             0, 32'h1234BEEF,  0,     3, 7, 3'b000)); // 29
        vecs.push_back(mk(1, 1, 0, 0, 0, A,     32'hCAFEF00D,  0, 0,             A,     3, 7, 3'b100)); // 30 store beats load
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0,             0, 0,             0,     3, 7, 3'b000)); // 31 no miss counted

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            check($sformatf("v%0d cpu_rd", i), cpu_rd, vecs[i].e_rd);
            check($sformatf("v%0d mem_a", i), mem_a, vecs[i].e_mem_a);
            check($sformatf("v%0d strobes", i), {29'b0, mem_sw, mem_sh, mem_sb}, {29'b0, vecs[i].e_strb});
            check($sformatf("v%0d hit_count", i), {16'b0, hit_count}, {16'b0, vecs[i].e_hc});
            check($sformatf("v%0d miss_count", i), {16'b0, miss_count}, {16'b0, vecs[i].e_mc});
        end

        check("ram A", ram[0], 32'hCAFEF00D);
        check("ram B", ram[8], 32'h1234BEEF);

        // Reset dropped in the middle of a refill.
        @(negedge clk);
        cpu_re = 1; cpu_sw = 0; cpu_sh = 0; cpu_sb = 0; flush = 0; cpu_addr = A;
        #1;
        check("rst seq miss stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        rst_n  = 1'b0;
        cpu_sb = 1'b1;
        #1;
        check("rst stall", {31'b0, stall}, 32'h0);
        check("rst mem_sb", {31'b0, mem_sb}, 32'h0);
        check("rst mem_a", mem_a, 32'h0);
        check("rst hit_count", {16'b0, hit_count}, 32'h0);
        check("rst miss_count", {16'b0, miss_count}, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cpu_sb = 1'b0;
        #1;
        check("post-rst load misses", {31'b0, stall}, 32'h1);
        check("post-rst cpu_rd", cpu_rd, 32'h0);
        @(negedge clk);
        #1;
        check("post-rst miss_count", {16'b0, miss_count}, 32'h1);
        @(negedge clk);
        #1;
        check("post-rst fill data", cpu_rd, 32'hCAFEF00D);
        cpu_re = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
